// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: payload widths and occupancy encodings shared by all pipeline stage registers
package pipe_stage_reg_pkg;
  localparam int IF_ID_W  = 96;
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 105;
  localparam int MEM_WB_W = 71;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } occ_e;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: up-counter that sticks at all-ones, cleared only by reset
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = IF_ID_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  occ_e              state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              in_xfer, out_xfer;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              skid_valid;
  assign skid_valid = state_q == ST_SKID;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
    end
  end
  // A flush discards whatever would have been loaded this edge
  always_comb begin
    state_d = flush                ? ST_EMPTY
            : state_q == ST_EMPTY  ? (in_xfer ? ST_FULL : ST_EMPTY)
            : state_q == ST_FULL   ? (in_xfer == out_xfer ? ST_FULL : in_xfer ? ST_SKID : ST_EMPTY)
            : (out_xfer ? ST_FULL : ST_SKID);
    data_d  = (!flush && in_xfer && (state_q == ST_EMPTY || out_xfer)) ? in_data
            : (!flush && skid_valid && out_xfer) ? skid_q : data_q;
    skid_d  = (!flush && state_q == ST_FULL && in_xfer && !out_xfer) ? in_data : skid_q;
  end
  always_comb begin
    in_ready  = !skid_valid;
    out_valid = state_q != ST_EMPTY;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    state_d = flush ? ST_EMPTY : in_xfer ? ST_FULL : out_xfer ? ST_EMPTY : state_q;
    data_d  = (!flush && in_xfer) ? in_data : data_q;
  end
  always_comb begin
    in_ready  = state_q == ST_EMPTY || out_ready;
    out_valid = state_q != ST_EMPTY;
  end
`endif
  assign out_data = data_q;
  pipe_sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_valid && !out_ready),
    .cnt_o (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg against a queue-based model
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic          clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;
  int            checks = 0, errors = 0;
  logic [DW-1:0] mq[$];
  int            m_cnt = 0;
  bit            m_ov, m_ir, mon_en = 0;
  logic [DW-1:0] pend[$], got[$], sent[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return mq.size() == 0 || out_ready;
`endif
  endfunction

  // Model: FIFO of held payloads, capacity 1 (or 2 with skid)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      m_ov = mq.size() > 0;
      m_ir = m_ready();
      if (m_ov && !out_ready && m_cnt < CMAX) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (m_ov && out_ready) void'(mq.pop_front());
        if (in_valid && m_ir) mq.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("in_ready", DW'(in_ready), DW'(m_ready()));
      chk("out_valid", DW'(out_valid), DW'(mq.size() > 0));
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      chk("stall_cnt", DW'(stall_cnt), DW'(m_cnt));
    end
  end

  task automatic load(input bit gap);
    in_valid = pend.size() > 0 && !gap;
    in_data  = pend.size() > 0 ? pend[0] : '0;
  endtask

  task automatic step();
    bit acc;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    #1;
    if (acc) begin
      sent.push_back(in_data);
      if (pend.size() > 0) void'(pend.pop_front());
    end
    load(0);
  endtask

  task automatic pulse_rst(string tag);
    #2 rst = 1;
    #1;
    chk({tag, "_valid"}, DW'(out_valid), 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_stall"}, DW'(stall_cnt), 0);
    chk({tag, "_in_ready"}, DW'(in_ready), 1);
    pend.delete();
    in_valid = 0;
    in_data  = '0;
    flush    = 0;
    @(negedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nd;
    #12;
    chk("rst_valid", DW'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_stall", DW'(stall_cnt), 0);
    chk("rst_in_ready", DW'(in_ready), 1);
    @(negedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    mon_en = 1;
    // streaming, one payload per cycle
    out_ready = 1;
    for (int i = 1; i <= 8; i++) pend.push_back(DW'(i));
    load(0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("stream_valid", DW'(out_valid), 1);
      chk("stream_data", out_data, DW'(i));
    end
    repeat (2) step();
    // back-pressure
    got.delete();
    out_ready = 0;
    pend = '{32'hA, 32'hB, 32'hC};
    load(0);
    repeat (4) step();
    chk("bp_in_ready", DW'(in_ready), 0);
    chk("bp_hold", out_data, 32'hA);
    chk("bp_stall", DW'(stall_cnt), 3);
    out_ready = 1;
    repeat (6) step();
    chk("bp_count", DW'(got.size()), 3);
    if (got.size() == 3) begin
      chk("bp_order0", got[0], 32'hA);
      chk("bp_order1", got[1], 32'hB);
      chk("bp_order2", got[2], 32'hC);
    end
    chk("bp_stall_hold", DW'(stall_cnt), 3);
    // flush with entries held and a live input
    got.delete();
    out_ready = 0;
    pend = '{32'h31, 32'h32};
    load(0);
    repeat (3) step();
    pend.delete();
    in_valid = 1;
    in_data  = 32'hD;
    flush    = 1;
    step();
    flush = 0;
    chk("flush_valid", DW'(out_valid), 0);
    out_ready = 1;
    pend = '{32'hE};
    load(0);
    step();
    chk("flush_next_valid", DW'(out_valid), 1);
    chk("flush_next_data", out_data, 32'hE);
    step();
    pend = '{32'hD};
    load(0);
    flush = 1;
    step();
    flush = 0;
    chk("flush_empty_valid", DW'(out_valid), 0);
    repeat (2) step();
    nd = 0;
    foreach (got[i]) if (got[i] == 32'hD) nd++;
    chk("flush_discard", DW'(nd), 0);
    // reset mid-stream with entries held
    out_ready = 0;
    pend = '{32'h51, 32'h52};
    load(0);
    repeat (3) step();
    pulse_rst("mid_rst");
    // stall counter saturation
    out_ready = 0;
    pend = '{32'h61};
    load(0);
    repeat (20) step();
    chk("sat_stall", DW'(stall_cnt), CMAX);
    flush = 1;
    step();
    flush = 0;
    chk("sat_after_flush", DW'(stall_cnt), CMAX);
    chk("sat_flush_valid", DW'(out_valid), 0);
    step();
    chk("sat_hold", DW'(stall_cnt), CMAX);
    pulse_rst("sat_rst");
    // toggling out_ready, scoreboarded for loss/duplication
    got.delete();
    sent.delete();
    for (int i = 0; i < 16; i++) pend.push_back(32'h100 + DW'(i));
    load(0);
    for (int c = 0; c < 40; c++) begin
      out_ready = ~out_ready;
`ifndef PIPE_STAGE_SKID_EN
      #1;
      if (out_valid) chk("ready_follows", DW'(in_ready), DW'(out_ready));
`endif
      step();
    end
    out_ready = 1;
    repeat (4) step();
    chk("sb_count", DW'(got.size()), 16);
    if (got.size() == 16)
      foreach (got[i]) chk("sb_item", got[i], 32'h100 + DW'(i));
    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if (pend.size() < 4) pend.push_back($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 31) == 0;
      load($urandom_range(0, 3) == 0);
      step();
    end
    flush     = 0;
    out_ready = 1;
    pend.delete();
    load(0);
    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
